// File: rtl/spi2apb_bridge.sv
// SPI mode-0 slave that turns each (8 + DATA_WIDTH)-bit frame into one APB3 transfer.
// Everything runs on sclk; the host keeps clocking after a frame to finish the bus cycle.
module spi2apb_bridge #(
  parameter int BANK_NUM   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  sclk,
  input  logic                  resetn,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  b_pclk,
  output logic                  b_presetn,
  output logic [BANK_NUM-1:0]   b_psel,
  output logic                  b_penable,
  output logic                  b_pwrite,
  output logic [ADDR_WIDTH-1:0] b_paddr,
  output logic [DATA_WIDTH-1:0] b_pwdata,
  input  logic [DATA_WIDTH-1:0] b_prdata,
  input  logic                  b_pready
);

  localparam int F  = 8 + DATA_WIDTH;
  localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int CW = $clog2(F + 1);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] F_C  = CW'(F);
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [CW-1:0]           cnt_r;
  logic [F-2:0]            rx_r;
  logic [DATA_WIDTH-1:0]   rdata_r, rdata_nxt_s;
  logic [BANK_NUM-1:0]     psel_r, psel_nxt_s, psel_dec_s;
  logic                    penable_r, penable_nxt_s;
  logic                    pwrite_r, pwrite_nxt_s;
  logic [ADDR_WIDTH-1:0]   paddr_r, paddr_nxt_s;
  logic [DATA_WIDTH-1:0]   pwdata_r, pwdata_nxt_s;
  logic                    miso_r, miso_nxt_s;

  logic                    clr_n_s;
  logic [F-1:0]            frame_s;
  logic                    frame_done_s;
  logic                    rw_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [BW-1:0]           bank_s;
  logic [DATA_WIDTH-1:0]   data_s;
  logic                    bank_ok_s;
  logic [IW-1:0]           rd_idx_s;

  // Deasserting ss throws away any partial frame, independent of sclk.
  assign clr_n_s      = resetn & ~ss;
  assign frame_s      = {rx_r, mosi};
  assign frame_done_s = (cnt_r == (F_C - CW'(1)));
  assign rw_s         = frame_s[F-1];
  assign addr_s       = frame_s[DATA_WIDTH +: ADDR_WIDTH];
  assign bank_s       = frame_s[DATA_WIDTH+ADDR_WIDTH +: BW];
  assign data_s       = frame_s[DATA_WIDTH-1:0];
  assign bank_ok_s    = (32'(bank_s) < BANK_NUM);
  assign psel_dec_s   = BANK_NUM'(1'b1) << bank_s;
  assign rd_idx_s     = IW'(F_C - CW'(1) - cnt_r);

  // Receive shift register and saturating bit counter.
  always_ff @(posedge sclk or negedge clr_n_s) begin
    if (!clr_n_s) begin
      cnt_r <= '0;
      rx_r  <= '0;
    end else if (cnt_r != F_C) begin
      cnt_r <= cnt_r + CW'(1);
      rx_r  <= frame_s[F-2:0];
    end else begin
      cnt_r <= cnt_r;
      rx_r  <= rx_r;
    end
  end

  // APB next-state and next-output decode.
  always_comb begin
    state_nxt_s   = state_r;
    psel_nxt_s    = psel_r;
    penable_nxt_s = penable_r;
    pwrite_nxt_s  = pwrite_r;
    paddr_nxt_s   = paddr_r;
    pwdata_nxt_s  = pwdata_r;
    rdata_nxt_s   = rdata_r;
    case (state_r)
      IDLE: begin
        if (frame_done_s && bank_ok_s) begin
          state_nxt_s  = SETUP;
          psel_nxt_s   = psel_dec_s;
          paddr_nxt_s  = addr_s;
          pwrite_nxt_s = rw_s;
          if (rw_s) begin
            pwdata_nxt_s = data_s;
          end else begin
            pwdata_nxt_s = pwdata_r;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s   = ACCESS;
        penable_nxt_s = 1'b1;
      end
      ACCESS: begin
        if (b_pready) begin
          if (!pwrite_r) begin
            rdata_nxt_s = b_prdata;
          end else begin
            rdata_nxt_s = rdata_r;
          end
          state_nxt_s   = IDLE;
          psel_nxt_s    = '0;
          penable_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        psel_nxt_s    = '0;
        penable_nxt_s = 1'b0;
      end
    endcase
  end

  // APB state, bus outputs and captured read data.
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      psel_r    <= '0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= '0;
      pwdata_r  <= '0;
      rdata_r   <= '0;
    end else begin
      state_r   <= state_nxt_s;
      psel_r    <= psel_nxt_s;
      penable_r <= penable_nxt_s;
      pwrite_r  <= pwrite_nxt_s;
      paddr_r   <= paddr_nxt_s;
      pwdata_r  <= pwdata_nxt_s;
      rdata_r   <= rdata_nxt_s;
    end
  end

  // Data phase of every frame replays the last completed read, MSB first.
  always_comb begin
    miso_nxt_s = 1'b0;
    if ((cnt_r >= DW_C) && (cnt_r < F_C)) begin
      miso_nxt_s = rdata_r[rd_idx_s];
    end else begin
      miso_nxt_s = 1'b0;
    end
  end

  // MISO launches on the falling edge so the host samples it on the next rising edge.
  always_ff @(negedge sclk or negedge clr_n_s) begin
    if (!clr_n_s) begin
      miso_r <= 1'b0;
    end else begin
      miso_r <= miso_nxt_s;
    end
  end

  assign miso      = miso_r;
  assign b_pclk    = sclk;
  assign b_presetn = resetn;
  assign b_psel    = psel_r;
  assign b_penable = penable_r;
  assign b_pwrite  = pwrite_r;
  assign b_paddr   = paddr_r;
  assign b_pwdata  = pwdata_r;

endmodule

// File: tb/tb_spi2apb_bridge.sv
// Bench for spi2apb_bridge: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized frames and bus responses.
module tb_spi2apb_bridge;

  localparam int F = 16;

  logic       sclk = 1'b0;
  logic       resetn, ss, mosi, miso;
  logic       b_pclk, b_presetn;
  logic [1:0] b_psel;
  logic       b_penable, b_pwrite;
  logic [2:0] b_paddr;
  logic [7:0] b_pwdata, b_prdata;
  logic       b_pready;

  logic       rand_bus, dir_pready;
  logic [7:0] dir_prdata;

  int checks = 0;
  int errors = 0;

  // model state (frame level)
  int         m_bits;
  logic [15:0] m_frame;
  int         m_phase;
  logic [1:0] m_psel;
  logic       m_pen, m_pwr;
  logic [2:0] m_paddr;
  logic [7:0] m_pwdata, m_rdata;

  int         setups = 0;
  logic [7:0] last_wdata = 8'h00;
  logic       last_wr = 1'b0;

  spi2apb_bridge #(.BANK_NUM(2), .DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .sclk(sclk), .resetn(resetn), .ss(ss), .mosi(mosi), .miso(miso),
    .b_pclk(b_pclk), .b_presetn(b_presetn), .b_psel(b_psel), .b_penable(b_penable),
    .b_pwrite(b_pwrite), .b_paddr(b_paddr), .b_pwdata(b_pwdata),
    .b_prdata(b_prdata), .b_pready(b_pready)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave response driver: directed values or random ready/data.
  always @(negedge sclk) begin
    #3;
    if (rand_bus) begin
      b_pready = ($urandom_range(0, 2) != 0);
      b_prdata = 8'($urandom);
    end else begin
      b_pready = dir_pready;
      b_prdata = dir_prdata;
    end
  end

  // Reference model: one frame of F bits -> one SETUP, one ACCESS, done when ready.
  always @(posedge sclk or negedge resetn) begin : model
    logic done;
    done = 1'b0;
    if (!resetn) begin
      m_bits = 0; m_frame = 16'h0000; m_phase = 0; m_psel = 2'b00;
      m_pen = 1'b0; m_pwr = 1'b0; m_paddr = 3'd0; m_pwdata = 8'h00; m_rdata = 8'h00;
    end else begin
      if (ss) begin
        m_bits = 0;
        m_frame = 16'h0000;
      end else if (m_bits < F) begin
        m_frame = {m_frame[14:0], mosi};
        m_bits++;
        done = (m_bits == F);
      end
      if (m_phase == 2) begin
        if (b_pready) begin
          if (!m_pwr) m_rdata = b_prdata;
          m_psel = 2'b00; m_pen = 1'b0; m_phase = 0;
        end
      end else if (m_phase == 1) begin
        m_pen = 1'b1; m_phase = 2;
      end else if (done) begin
        m_psel  = 2'b01 << m_frame[11];
        m_paddr = m_frame[10:8];
        m_pwr   = m_frame[15];
        if (m_frame[15]) m_pwdata = m_frame[7:0];
        m_phase = 1;
      end
    end
  end

  // Bus outputs compared against the model after every rising edge.
  always @(posedge sclk) begin
    #1;
    chk("psel",    32'(b_psel),    32'(m_psel));
    chk("penable", 32'(b_penable), 32'(m_pen));
    chk("pwrite",  32'(b_pwrite),  32'(m_pwr));
    chk("paddr",   32'(b_paddr),   32'(m_paddr));
    chk("pwdata",  32'(b_pwdata),  32'(m_pwdata));
    chk("pclk",    32'(b_pclk),    32'(sclk));
    chk("presetn", 32'(b_presetn), 32'(resetn));
    if (b_psel != 2'b00 && !b_penable) begin
      setups++;
      last_wdata = b_pwdata;
      last_wr = b_pwrite;
    end
  end

  // MISO compared just before the host samples it.
  always @(negedge sclk) begin : miso_chk
    logic exp;
    #4;
    exp = 1'b0;
    if (resetn && !ss && m_bits >= 8 && m_bits < F) exp = m_rdata[15 - m_bits];
    chk("miso", 32'(miso), 32'(exp));
  end

  task automatic xfer(input logic [15:0] f, input int nbits, output logic [15:0] rx);
    rx = 16'h0000;
    @(negedge sclk); #2;
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15 - i];
      @(posedge sclk);
      rx = {rx[14:0], miso};
      @(negedge sclk); #2;
    end
    ss = 1'b1;
    mosi = 1'b0;
  endtask

  initial begin
    logic [15:0] rx, f;
    int s0, nb;
    resetn = 1'b0; ss = 1'b1; mosi = 1'b0;
    rand_bus = 1'b0; dir_pready = 1'b1; dir_prdata = 8'h00;
    #23;
    chk("rst_psel",    32'(b_psel),    32'h0);
    chk("rst_penable", 32'(b_penable), 32'h0);
    chk("rst_paddr",   32'(b_paddr),   32'h0);
    chk("rst_miso",    32'(miso),      32'h0);
    @(negedge sclk); #2 resetn = 1'b1;
    repeat (2) @(negedge sclk);

    // write 0xD5F9: bank 0, addr 5, data 0xF9
    xfer(16'hD5F9, 16, rx);
    chk("wr_psel",    32'(b_psel),    32'h1);
    chk("wr_paddr",   32'(b_paddr),   32'h5);
    chk("wr_pwrite",  32'(b_pwrite),  32'h1);
    chk("wr_pwdata",  32'(b_pwdata),  32'hF9);
    chk("wr_penable", 32'(b_penable), 32'h0);
    @(posedge sclk); #2;
    chk("wr_access", 32'(b_penable), 32'h1);
    @(posedge sclk); #2;
    chk("wr_done_psel", 32'(b_psel),    32'h0);
    chk("wr_done_pen",  32'(b_penable), 32'h0);

    // read 0x1A00: bank 1, addr 2, slave returns 0x3C
    dir_prdata = 8'h3C;
    xfer(16'h1A00, 16, rx);
    chk("rd_psel",   32'(b_psel),   32'h2);
    chk("rd_pwrite", 32'(b_pwrite), 32'h0);
    chk("rd_paddr",  32'(b_paddr),  32'h2);
    repeat (2) @(posedge sclk); #2;
    chk("rd_done", 32'(b_psel), 32'h0);
    dir_prdata = 8'h00;
    xfer(16'h8000, 16, rx);
    chk("rd_miso_data", 32'(rx[7:0]),  32'h3C);
    chk("rd_miso_hdr",  32'(rx[15:8]), 32'h00);
    repeat (3) @(posedge sclk);

    // three wait states on a write of 0x5A to bank 0 addr 6
    dir_pready = 1'b0;
    xfer(16'h965A, 16, rx);
    @(posedge sclk);
    for (int i = 0; i < 3; i++) begin
      @(posedge sclk); #2;
      chk("ws_penable", 32'(b_penable), 32'h1);
      chk("ws_psel",    32'(b_psel),    32'h1);
      chk("ws_paddr",   32'(b_paddr),   32'h6);
      chk("ws_pwdata",  32'(b_pwdata),  32'h5A);
    end
    @(negedge sclk); #2 dir_pready = 1'b1;
    @(posedge sclk); #2;
    chk("ws_done", 32'(b_psel), 32'h0);

    // aborted partial frame followed by a full one
    s0 = setups;
    xfer(16'hD5F9, 5, rx);
    xfer(16'hD5F9, 16, rx);
    repeat (3) @(posedge sclk); #2;
    chk("abort_count", 32'(setups - s0), 32'h1);
    chk("abort_data",  32'(last_wdata),  32'hF9);
    chk("abort_wr",    32'(last_wr),     32'h1);

    // second frame arriving while the first waits in ACCESS is dropped
    dir_pready = 1'b0;
    s0 = setups;
    xfer(16'h9133, 16, rx);
    xfer(16'hCA77, 16, rx);
    chk("busy_psel",  32'(b_psel),  32'h1);
    chk("busy_paddr", 32'(b_paddr), 32'h1);
    dir_pready = 1'b1;
    repeat (3) @(posedge sclk); #2;
    chk("busy_count", 32'(setups - s0), 32'h1);
    chk("busy_done",  32'(b_psel),      32'h0);

    // reset while in ACCESS
    dir_pready = 1'b0;
    xfer(16'hD5F9, 16, rx);
    repeat (2) @(posedge sclk);
    @(negedge sclk); #2 resetn = 1'b0;
    #1;
    chk("rstx_psel",    32'(b_psel),    32'h0);
    chk("rstx_penable", 32'(b_penable), 32'h0);
    chk("rstx_pwrite",  32'(b_pwrite),  32'h0);
    chk("rstx_paddr",   32'(b_paddr),   32'h0);
    chk("rstx_pwdata",  32'(b_pwdata),  32'h0);
    chk("rstx_miso",    32'(miso),      32'h0);
    repeat (2) @(negedge sclk); #2;
    resetn = 1'b1; dir_pready = 1'b1;
    xfer(16'hD5F9, 16, rx);
    chk("post_psel",   32'(b_psel),   32'h1);
    chk("post_paddr",  32'(b_paddr),  32'h5);
    chk("post_pwdata", 32'(b_pwdata), 32'hF9);
    repeat (3) @(posedge sclk);

    // randomized frames, partial frames, gaps and slave responses
    rand_bus = 1'b1;
    for (int n = 0; n < 80; n++) begin
      f  = 16'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
      xfer(f, nb, rx);
      repeat ($urandom_range(0, 6)) @(negedge sclk);
    end
    rand_bus = 1'b0;
    dir_pready = 1'b1;
    repeat (10) @(negedge sclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
